mips_muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.

---
 rtl/mips_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the pipelined MIPS core.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they behave as MULTU/DIVU.
module mips_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hilo_rd,
    input  logic             hilo_sel,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             stall_req
);

    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV} stateT;

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic             opSigned;
    logic             negQ;
    logic             negR;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;

    logic             signedReq;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [2*WIDTH-1:0] mulExtA;
    logic [2*WIDTH-1:0] mulExtB;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             canSub;
    logic [WIDTH-1:0] fixQ;
    logic [WIDTH-1:0] fixR;

    // op 000 (MULT) and 010 (DIV) are the signed variants
    assign signedReq = SIGNED_EN && !op[0];
    assign absA      = (signedReq && a[WIDTH-1]) ? -a : a;
    assign absB      = (signedReq && b[WIDTH-1]) ? -b : b;

    // Low 2*WIDTH bits of the product of sign-extended operands is the signed product
    assign mulExtA = {{WIDTH{opSigned & aReg[WIDTH-1]}}, aReg};
    assign mulExtB = {{WIDTH{opSigned & bReg[WIDTH-1]}}, bReg};
    assign product = mulExtA * mulExtB;

    // Restoring step on magnitudes: dividend bits shift out of quoReg into remReg
    assign shifted = {remReg, quoReg[WIDTH-1]};
    assign canSub  = shifted >= {1'b0, bReg};
    assign diff    = shifted[WIDTH-1:0] - bReg;
    assign fixQ    = negQ ? -quoReg : quoReg;
    assign fixR    = negR ? -remReg : remReg;

    assign busy      = (state != IDLE);
    assign stall_req = busy & (start | hilo_rd);
    assign hilo_out  = hilo_sel ? hiReg : loReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            opSigned <= 1'b0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
            aReg     <= '0;
            bReg     <= '0;
            remReg   <= '0;
            quoReg   <= '0;
            hiReg    <= '0;
            loReg    <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        case (op)
                            3'b000, 3'b001: begin
                                state    <= MUL;
                                cnt      <= '0;
                                aReg     <= a;
                                bReg     <= b;
                                opSigned <= signedReq;
                            end
                            3'b010, 3'b011: begin
                                state  <= DIV;
                                cnt    <= '0;
                                aReg   <= a;
                                bReg   <= absB;
                                quoReg <= absA;
                                remReg <= '0;
                                negQ   <= signedReq & (a[WIDTH-1] ^ b[WIDTH-1]);
                                negR   <= signedReq & a[WIDTH-1];
                            end
                            3'b100:  hiReg <= a;
                            3'b101:  loReg <= a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
                        {hiReg, loReg} <= product;
                        done           <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (cnt == CNT_W'(WIDTH)) begin
                        // Sign-fix cycle; zero divisor returns all-ones quotient and the raw dividend
                        if (bReg == '0) begin
                            loReg    <= '1;
                            hiReg    <= aReg;
                            div_zero <= 1'b1;
                        end else begin
                            loReg <= fixQ;
                            hiReg <= fixR;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        remReg <= canSub ? diff : shifted[WIDTH-1:0];
                        quoReg <= {quoReg[WIDTH-2:0], canSub};
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed corner cases plus random ops
// compared against an arithmetic reference model of HI/LO.
module tb_mips_muldiv_unit;
    localparam int W  = 32;
    localparam int MC = 4;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_MODEL = 1'b1;
`else
    localparam bit SIGNED_MODEL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         hilo_rd;
    logic         hilo_sel;
    logic [W-1:0] hilo_out;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic         stall_req;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] mHi   = '0;
    logic [W-1:0] mLo   = '0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .hilo_rd(hilo_rd), .hilo_sel(hilo_sel),
        .hilo_out(hilo_out), .busy(busy), .done(done),
        .div_zero(div_zero), .stall_req(stall_req)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_model();
        exp_q.push_back(mHi);
        exp_q.push_back(mLo);
    endtask

    task automatic read_check(input string tag);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        eh = exp_q.pop_front();
        el = exp_q.pop_front();
        hilo_sel = 1'b1;
        #1 check({tag, ".hi"}, hilo_out, eh);
        hilo_sel = 1'b0;
        #1 check({tag, ".lo"}, hilo_out, el);
    endtask

    // ---------------- reference model ----------------
    task automatic model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            output bit zero);
        bit          sgn;
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        zero = 1'b0;
        sgn  = SIGNED_MODEL && (o == 3'd0 || o == 3'd2);
        sx   = sgn ? longint'($signed(x)) : longint'(x);
        sy   = sgn ? longint'($signed(y)) : longint'(y);
        case (o)
            3'd0, 3'd1: begin
                p   = sx * sy;
                mHi = p[63:32];
                mLo = p[31:0];
            end
            3'd2, 3'd3: begin
                if (y == '0) begin
                    zero = 1'b1;
                    mLo  = '1;
                    mHi  = x;
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    mLo = q[31:0];
                    mHi = r[31:0];
                end
            end
            3'd4:    mHi = x;
            3'd5:    mLo = x;
            default: ;
        endcase
        push_model();
    endtask

    // ---------------- drivers ----------------
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y);
        bit z;
        int cycles;
        int expC;
        issue(o, x, y);
        model_op(o, x, y, z);
        if (o <= 3'd3) begin
            expC   = (o >= 3'd2) ? W + 1 : MC;
            cycles = 0;
            while (busy === 1'b1 && cycles < 100) begin
                cycles++;
                @(negedge clk);
            end
            check({tag, ".busy_cycles"}, W'(cycles), W'(expC));
            check({tag, ".done"}, W'(done), W'(1));
            check({tag, ".div_zero"}, W'(div_zero), W'(z));
        end else begin
            check({tag, ".busy"}, W'(busy), W'(0));
            check({tag, ".done"}, W'(done), W'(0));
        end
        read_check(tag);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [2:0]   ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        bit           z;

        reset = 1'b1; start = 1'b0; abort = 1'b0; hilo_rd = 1'b0; hilo_sel = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset.busy", W'(busy), W'(0));
        check("reset.done", W'(done), W'(0));
        check("reset.div_zero", W'(div_zero), W'(0));
        check("reset.stall_req", W'(stall_req), W'(0));
        push_model();
        read_check("reset");

        // Consecutive run_op calls start in the done cycle, exercising back-to-back issue
        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7);
        run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2);
        run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5);
        run_op("divu_by0", 3'd3, 32'd5, 32'd0);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        run_op("div_by0", 3'd2, 32'h80000005, 32'd0);
        run_op("mthi", 3'd4, 32'hCAFE0001, 32'd0);
        run_op("mtlo", 3'd5, 32'h0BAD0002, 32'd0);

        // Unknown ops leave HI/LO and busy untouched
        issue(3'd6, 32'h11111111, 32'h2);
        check("op6.busy", W'(busy), W'(0));
        issue(3'd7, 32'h22222222, 32'h3);
        check("op7.busy", W'(busy), W'(0));
        push_model();
        read_check("unknown_op");

        // Stall request during a multiply, plus a second start that must be ignored
        hilo_rd = 1'b1;
        #1 check("stall.idle", W'(stall_req), W'(0));
        issue(3'd1, 32'h00012345, 32'h00000100);
        model_op(3'd1, 32'h00012345, 32'h00000100, z);
        for (int i = 0; i < MC; i++) begin
            check("stall.busy", W'(busy), W'(1));
            check("stall.req", W'(stall_req), W'(1));
            if (i == 1) begin
                op = 3'd3; a = 32'd999; b = 32'd3; start = 1'b1;
                #1 check("stall.req_start", W'(stall_req), W'(1));
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("stall.after_busy", W'(busy), W'(0));
        check("stall.after_req", W'(stall_req), W'(0));
        check("stall.done", W'(done), W'(1));
        hilo_rd = 1'b0;
        read_check("stall_ignore");
        @(negedge clk);
        check("ignored_start.busy", W'(busy), W'(0));

        // Abort in the middle of a divide
        run_op("mtlo_1234", 3'd5, 32'h00001234, 32'd0);
        issue(3'd3, 32'hDEADBEEF, 32'd3);
        repeat (9) @(negedge clk);
        check("abort.pre_busy", W'(busy), W'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.busy", W'(busy), W'(0));
        check("abort.done", W'(done), W'(0));
        @(negedge clk);
        check("abort.done_late", W'(done), W'(0));
        push_model();
        read_check("abort");

        // start together with abort in IDLE is dropped
        op = 3'd5; a = 32'hDEAD0000; abort = 1'b1; start = 1'b1;
        @(negedge clk);
        op = 3'd3; a = 32'd50; b = 32'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort.busy", W'(busy), W'(0));
        push_model();
        read_check("idle_abort");

        // Randomised ops against the model
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 5));
            rx = $urandom;
            if ($urandom_range(0, 9) == 0) rx = 32'h80000000;
            case ($urandom_range(0, 7))
                0:       ry = '0;
                1:       ry = W'($urandom_range(1, 15));
                2:       ry = 32'hFFFFFFFF;
                default: ry = $urandom;
            endcase
            run_op("rand", ro, rx, ry);
        end

        // Asynchronous reset in the middle of a multiply
        run_op("pre_reset_mthi", 3'd4, 32'hA5A5A5A5, 32'd0);
        hilo_rd = 1'b1;
        issue(3'd1, 32'h00000003, 32'h00000007);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check("async_reset.busy", W'(busy), W'(0));
        check("async_reset.done", W'(done), W'(0));
        check("async_reset.stall_req", W'(stall_req), W'(0));
        hilo_sel = 1'b1;
        #1 check("async_reset.hi", hilo_out, W'(0));
        hilo_sel = 1'b0;
        #1 check("async_reset.lo", hilo_out, W'(0));
        @(negedge clk);
        reset   = 1'b0;
        hilo_rd = 1'b0;
        mHi     = '0;
        mLo     = '0;
        run_op("post_reset_divu", 3'd3, 32'd1000, 32'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
